// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared timing constants for the VGA display pipeline (800x600 @ 60 Hz,
// 40 MHz pixel clock). The timing source and every draw stage import this
// package so that they agree on counter width and default geometry.
//
// Contents:
//   CNT_W            - width of the pixel/line counters (12)
//   cnt_t            - counter type
//   DEF_H_* / DEF_V_* - default active/porch/sync sizes
//   DEF_H_TOTAL/DEF_V_TOTAL - derived totals (1056 / 628)
//   CNT_ONE          - counter-width increment constant
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int CNT_W = 12;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;

  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 23;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam cnt_t CNT_ONE = cnt_t'(1);

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One timing axis (horizontal or vertical). Counts 0..TOTAL-1 while enabled,
// wrapping to 0, and registers sync/blank flags decoded from the *next* count
// so that count and flags leave the same flop edge together.
//
// Ports:
//   clk_i    - pixel clock
//   rst_ni   - asynchronous active-low reset
//   en_i     - advance the count this cycle
//   count_o  - registered count
//   sync_o   - registered sync flag (SYNC_START <= count < SYNC_START+SYNC_LEN)
//   blnk_o   - registered blank flag (count >= ACTIVE)
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL      = DEF_H_TOTAL,
  parameter int ACTIVE     = DEF_H_ACTIVE,
  parameter int SYNC_START = DEF_H_ACTIVE + DEF_H_FP,
  parameter int SYNC_LEN   = DEF_H_SYNC
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output cnt_t count_o,
  output logic sync_o,
  output logic blnk_o
);

  localparam cnt_t LAST = cnt_t'(TOTAL - 1);
  localparam cnt_t ACT  = cnt_t'(ACTIVE);
  localparam cnt_t SS   = cnt_t'(SYNC_START);
  // One bit wider: the sync end may equal TOTAL, which can be 4096.
  localparam logic [CNT_W:0] SE = (CNT_W+1)'(SYNC_START + SYNC_LEN);

  cnt_t count_q, count_d;
  logic sync_q, sync_d;
  logic blnk_q, blnk_d;

  // Next count and flags decoded from that next count.
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      if (count_q == LAST) begin
        count_d = '0;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end else begin
      count_d = count_q;
    end
    sync_d = (count_d >= SS) && ({1'b0, count_d} < SE);
    blnk_d = (count_d >= ACT);
  end

  // Count and flag registers, cleared to the (0,0) active-pixel state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      sync_q  <= 1'b0;
      blnk_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
      blnk_q  <= blnk_d;
    end
  end

  assign count_o = count_q;
  assign sync_o  = sync_q;
  assign blnk_o  = blnk_q;

endmodule

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
// Producer of the VGA timing bus: pixel column/line counters with sync and
// blanking strobes. Every output is a flop; counts and strobes are produced
// on the same edge so each output word is self-consistent.
//
// Ports:
//   pclk          - pixel clock (40 MHz), rising edge
//   rst           - asynchronous active-low reset
//   hcount_out    - pixel column 0..H_TOTAL-1
//   hsync_out     - horizontal sync, active high
//   hblnk_out     - horizontal blanking
//   vcount_out    - line 0..V_TOTAL-1
//   vsync_out     - vertical sync, active high
//   vblnk_out     - vertical blanking
//   frame_cnt_out - frame counter, present only when VGA_TIMING_FRAME_CNT_EN
//                   is defined; increments on the (last,last) -> (0,0) edge
// -----------------------------------------------------------------------------
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic              pclk,
  input  logic              rst,
  output logic [CNT_W-1:0]  hcount_out,
  output logic              hsync_out,
  output logic              hblnk_out,
  output logic [CNT_W-1:0]  vcount_out,
  output logic              vsync_out,
  output logic              vblnk_out
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt_out
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((H_TOTAL > 4096) || (V_TOTAL > 4096)) begin : g_total_chk
    $fatal(1, "vga_timing: H_TOTAL/V_TOTAL exceed the 12-bit counter range");
  end

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);

  cnt_t hcount_s;
  cnt_t vcount_s;
  logic h_wrap_s;

  // End of line: the vertical axis advances on the same edge hcount wraps.
  assign h_wrap_s = (hcount_s == H_LAST);

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_LEN   (H_SYNC)
  ) u_h_axis (
    .clk_i   (pclk),
    .rst_ni  (rst),
    .en_i    (1'b1),
    .count_o (hcount_s),
    .sync_o  (hsync_out),
    .blnk_o  (hblnk_out)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_LEN   (V_SYNC)
  ) u_v_axis (
    .clk_i   (pclk),
    .rst_ni  (rst),
    .en_i    (h_wrap_s),
    .count_o (vcount_s),
    .sync_o  (vsync_out),
    .blnk_o  (vblnk_out)
  );

  assign hcount_out = hcount_s;
  assign vcount_out = vcount_s;

`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

  logic [15:0] frame_q;
  logic [15:0] frame_d;

  // Frame count advances on the edge that takes the counters back to (0,0).
  always_comb begin
    frame_d = frame_q;
    if (h_wrap_s && (vcount_s == V_LAST)) begin
      frame_d = frame_q + 16'd1;
    end else begin
      frame_d = frame_q;
    end
  end

  // Frame counter register.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      frame_q <= 16'd0;
    end else begin
      frame_q <= frame_d;
    end
  end

  assign frame_cnt_out = frame_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
`timescale 1ns/1ps
module tb_vga_timing;

  logic pclk = 1'b0;
  always #12.5 pclk = ~pclk;

  logic        rst_big, rst_small;
  logic [11:0] b_h, b_v, s_h, s_v;
  logic        b_hs, b_hb, b_vs, b_vb, s_hs, s_hb, s_vs, s_vb;
  logic [15:0] b_fc, s_fc;

  // Full-size geometry: line boundaries checked directly.
  vga_timing dut_big (
    .pclk(pclk), .rst(rst_big),
    .hcount_out(b_h), .hsync_out(b_hs), .hblnk_out(b_hb),
    .vcount_out(b_v), .vsync_out(b_vs), .vblnk_out(b_vb)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt_out(b_fc)
`endif
  );

  // Shrunk geometry (25 x 13, frame = 325 cycles) for whole-frame behaviour.
  vga_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_small (
    .pclk(pclk), .rst(rst_small),
    .hcount_out(s_h), .hsync_out(s_hs), .hblnk_out(s_hb),
    .vcount_out(s_v), .vsync_out(s_vs), .vblnk_out(s_vb)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt_out(s_fc)
`endif
  );

`ifndef VGA_TIMING_FRAME_CNT_EN
  assign b_fc = 16'd0;
  assign s_fc = 16'd0;
`endif

  typedef struct {
    int          n;
    logic [11:0] h, v;
    logic        hs, hb, vs, vb;
    logic [15:0] fc;
  } exp_t;

  exp_t qb[$];
  exp_t qs[$];
  int total = 0;
  int bad   = 0;
  int hs_rise = 0, vs_rise = 0;
  logic s_hs_prev = 1'b0, s_vs_prev = 1'b0;

  // Reference: state after n edges since reset release, from plain arithmetic.
  function automatic exp_t model(int n, int ha, int hf, int hsw, int hbp,
                                 int va, int vf, int vsw, int vbp);
    exp_t e;
    int ht, vt, h, line, v;
    ht   = ha + hf + hsw + hbp;
    vt   = va + vf + vsw + vbp;
    h    = n % ht;
    line = n / ht;
    v    = line % vt;
    e.n  = n;
    e.h  = 12'(h);
    e.v  = 12'(v);
    e.hb = (h >= ha);
    e.hs = (h >= ha + hf) && (h < ha + hf + hsw);
    e.vb = (v >= va);
    e.vs = (v >= va + vf) && (v < va + vf + vsw);
    e.fc = 16'((line / vt) % 65536);
    return e;
  endfunction

  function automatic exp_t mk(exp_t m, logic [11:0] h, logic [11:0] v,
                              logic hs, logic hb, logic vs, logic vb);
    exp_t e;
    e = m; e.h = h; e.v = v; e.hs = hs; e.hb = hb; e.vs = vs; e.vb = vb;
    return e;
  endfunction

  // Hand-computed boundary vectors for the 1056 x 628 geometry.
  function automatic exp_t dir_big(int n);
    exp_t m;
    m = model(n, 800, 40, 128, 88, 600, 1, 4, 23);
    case (n)
      0:    return mk(m, 12'd0,    12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      1:    return mk(m, 12'd1,    12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      799:  return mk(m, 12'd799,  12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      800:  return mk(m, 12'd800,  12'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      839:  return mk(m, 12'd839,  12'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      840:  return mk(m, 12'd840,  12'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      967:  return mk(m, 12'd967,  12'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      968:  return mk(m, 12'd968,  12'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      1055: return mk(m, 12'd1055, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      1056: return mk(m, 12'd0,    12'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      1057: return mk(m, 12'd1,    12'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      default: return m;
    endcase
  endfunction

  // Hand-computed vectors for the 25 x 13 geometry.
  function automatic exp_t dir_small(int n);
    exp_t m;
    m = model(n, 16, 2, 4, 3, 8, 1, 2, 2);
    case (n)
      199: return mk(m, 12'd24, 12'd7,  1'b0, 1'b1, 1'b0, 1'b0);
      200: return mk(m, 12'd0,  12'd8,  1'b0, 1'b0, 1'b0, 1'b1);
      224: return mk(m, 12'd24, 12'd8,  1'b0, 1'b1, 1'b0, 1'b1);
      225: return mk(m, 12'd0,  12'd9,  1'b0, 1'b0, 1'b1, 1'b1);
      274: return mk(m, 12'd24, 12'd10, 1'b0, 1'b1, 1'b1, 1'b1);
      275: return mk(m, 12'd0,  12'd11, 1'b0, 1'b0, 1'b0, 1'b1);
      324: return mk(m, 12'd24, 12'd12, 1'b0, 1'b1, 1'b0, 1'b1);
      325: return mk(m, 12'd0,  12'd0,  1'b0, 1'b0, 1'b0, 1'b0);
      343: return mk(m, 12'd18, 12'd0,  1'b1, 1'b1, 1'b0, 1'b0);
      default: return m;
    endcase
  endfunction

  function automatic exp_t zero_exp(int n);
    exp_t e;
    e.n = n; e.h = 12'd0; e.v = 12'd0;
    e.hs = 1'b0; e.hb = 1'b0; e.vs = 1'b0; e.vb = 1'b0; e.fc = 16'd0;
    return e;
  endfunction

  task automatic check(string name, exp_t e, logic [11:0] h, logic [11:0] v,
                       logic hs, logic hb, logic vs, logic vb, logic [15:0] fc);
    logic ok;
    ok = (h === e.h) && (v === e.v) && (hs === e.hs) && (hb === e.hb) &&
         (vs === e.vs) && (vb === e.vb);
`ifdef VGA_TIMING_FRAME_CNT_EN
    ok = ok && (fc === e.fc);
`endif
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s n=%0d got h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b fc=%0d want h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b fc=%0d",
               name, e.n, h, v, hs, hb, vs, vb, fc,
               e.h, e.v, e.hs, e.hb, e.vs, e.vb, e.fc);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare at the falling edge.
  always @(negedge pclk) begin : monitor
    exp_t e;
    if (qb.size() > 0) begin
      e = qb.pop_front();
      check("big", e, b_h, b_v, b_hs, b_hb, b_vs, b_vb, b_fc);
    end
    if (qs.size() > 0) begin
      e = qs.pop_front();
      check("small", e, s_h, s_v, s_hs, s_hb, s_vs, s_vb, s_fc);
      // Pulse counts over the second frame (edges 325..649).
      if (e.n >= 325 && e.n < 650) begin
        if (s_hs && !s_hs_prev) hs_rise++;
        if (s_vs && !s_vs_prev) vs_rise++;
      end
      s_hs_prev = s_hs;
      s_vs_prev = s_vs;
    end
  end

  initial begin
    rst_big   = 1'b0;
    rst_small = 1'b0;

    // Big geometry: reset hold, release, one line plus a bit.
    repeat (3) begin
      @(posedge pclk); #1;
      qb.push_back(zero_exp(-1));
    end
    @(posedge pclk); #1;
    rst_big = 1'b1;
    qb.push_back(dir_big(0));
    for (int i = 1; i <= 1100; i++) begin
      @(posedge pclk); #1;
      qb.push_back(dir_big(i));
    end

    // Small geometry: three full frames, then on to (19,5).
    @(posedge pclk); #1;
    rst_small = 1'b1;
    qs.push_back(dir_small(0));
    for (int i = 1; i <= 1118; i++) begin
      @(posedge pclk); #1;
      qs.push_back(dir_small(i));
    end

    // Mid-frame asynchronous reset while hsync is high.
    @(posedge pclk); #1;
    rst_small = 1'b0;
    #1;
    check("async_clr", zero_exp(-2), s_h, s_v, s_hs, s_hb, s_vs, s_vb, s_fc);
    qs.push_back(zero_exp(-3));
    repeat (2) begin
      @(posedge pclk); #1;
      qs.push_back(zero_exp(-3));
    end
    @(posedge pclk); #1;
    rst_small = 1'b1;
    qs.push_back(dir_small(0));
    for (int i = 1; i <= 60; i++) begin
      @(posedge pclk); #1;
      qs.push_back(dir_small(i));
    end

    @(negedge pclk); #1;
    total++;
    if (qb.size() != 0 || qs.size() != 0) begin
      bad++;
      $display("FAIL drain got big=%0d small=%0d want 0", qb.size(), qs.size());
    end
    total++;
    if (hs_rise != 13) begin
      bad++;
      $display("FAIL hsync_pulses got %0d want 13", hs_rise);
    end
    total++;
    if (vs_rise != 1) begin
      bad++;
      $display("FAIL vsync_pulses got %0d want 1", vs_rise);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
